// File: rtl/interleaver_pkg.sv
// interleaver_pkg: shared defaults and helpers for the interleaver delay elements
package interleaver_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_DEPTH_DEF = 16;
  function automatic int dsel_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction
  function automatic int clamp_delay(input int x, input int max_depth);
    return (x == 0) ? 1 : (x > max_depth) ? max_depth : x;
  endfunction
endpackage

// File: rtl/reg_stage.sv
// reg_stage: enabled register with async reset and sync clear
module reg_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/reg_delay_line.sv
// reg_delay_line: shift register with run-time selectable delay, valid, stall, flush and primed flag
module reg_delay_line
  import interleaver_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_DEPTH = MAX_DEPTH_DEF,
  parameter int DSEL_W = dsel_w(MAX_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [DSEL_W-1:0] delay_sel,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              valid_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              valid_out,
  output logic              primed,
  output logic [DSEL_W-1:0] active_delay
);
  logic [WIDTH:0] q [MAX_DEPTH];
  logic [WIDTH:0] tap;
  logic [DSEL_W-1:0] fill;
  logic [DSEL_W-1:0] dsel_c;
  assign dsel_c = DSEL_W'(clamp_delay(int'(delay_sel), MAX_DEPTH));
  for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
    logic [WIDTH:0] d;
    if (i == 0) begin : g_in
      assign d = {valid_in, data_in};
    end else begin : g_sh
      assign d = q[i-1];
    end
    reg_stage #(.W(WIDTH + 1)) u_stage (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .clr  (flush),
      .d    (d),
      .q    (q[i])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fill <= '0;
      active_delay <= dsel_c;
    end else if (flush) begin
      fill <= '0;
      active_delay <= dsel_c;
    end else if (en) begin
      fill <= (fill == active_delay) ? fill : fill + DSEL_W'(1);
    end
  always_comb begin
    tap = '0;
    for (int k = 0; k < MAX_DEPTH; k++)
      tap = (active_delay == DSEL_W'(k + 1)) ? q[k] : tap;
  end
  assign {valid_out, data_out} = tap;
  assign primed = (fill == active_delay);
endmodule

// File: tb/tb_reg_delay_line.sv
// tb_reg_delay_line: scoreboard-checked bench for reg_delay_line
module tb_reg_delay_line;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic flush = 1'b0;
  logic [4:0] delay_sel = 5'd4;
  logic [7:0] data_in = '0;
  logic valid_in = 1'b0;
  logic [7:0] data_out;
  logic valid_out;
  logic primed;
  logic [4:0] active_delay;
  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] sb [$];
  logic [8:0] exp_o = '0;
  int ad = 4;
  int fill = 0;

  always #5 clk = ~clk;

  reg_delay_line dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .flush       (flush),
    .delay_sel   (delay_sel),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .primed      (primed),
    .active_delay(active_delay)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int x);
    return (x == 0) ? 1 : (x > 16) ? 16 : x;
  endfunction

  task automatic model_clear(input int d);
    ad = d;
    fill = 0;
    exp_o = '0;
    sb.delete();
    repeat (d - 1) sb.push_back(9'h000);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_dout"}, 32'(data_out), 32'(exp_o[7:0]));
    check({tag, "_vout"}, 32'(valid_out), 32'(exp_o[8]));
    check({tag, "_primed"}, 32'(primed), 32'(fill == ad));
    check({tag, "_adel"}, 32'(active_delay), 32'(ad));
  endtask

  task automatic do_reset(input logic [4:0] dsel);
    delay_sel = dsel;
    en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear(clampi(int'(dsel)));
    check_all("reset");
  endtask

  task automatic cyc(input string tag, input logic e, input logic v, input logic [7:0] d);
    en = e;
    valid_in = v;
    data_in = d;
    @(posedge clk);
    #1;
    if (e) begin
      sb.push_back({v, d});
      exp_o = sb.pop_front();
      if (fill < ad) fill++;
    end
    check_all(tag);
  endtask

  task automatic do_flush(input logic [4:0] dsel);
    delay_sel = dsel;
    en = 1'b1;
    flush = 1'b1;
    valid_in = 1'b1;
    data_in = 8'hEE;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear(clampi(int'(dsel)));
    check_all("flush");
  endtask

  initial begin
    // latency and primed at delay 4
    do_reset(5'd4);
    for (int i = 1; i <= 3; i++) cyc("lat", 1'b1, 1'b1, 8'(i));
    check("pre_prime_vout", 32'(valid_out), 32'd0);
    cyc("lat", 1'b1, 1'b1, 8'h04);
    check("first_word", 32'(data_out), 32'h01);
    check("first_prime", 32'(primed), 32'd1);
    // stall after 0x03 has entered: restart stream
    do_reset(5'd4);
    for (int i = 1; i <= 3; i++) cyc("pre_stall", 1'b1, 1'b1, 8'(i));
    for (int i = 0; i < 3; i++) cyc("stall", 1'b0, 1'b1, 8'hFF);
    for (int i = 4; i <= 10; i++) cyc("post_stall", 1'b1, 1'b1, 8'(i));
    // delay_sel change without flush is ignored
    delay_sel = 5'd7;
    for (int i = 11; i <= 16; i++) cyc("dsel_ignored", 1'b1, 1'b1, 8'(i));
    do_flush(5'd7);
    for (int i = 32; i <= 42; i++) cyc("delay7", 1'b1, 1'b1, 8'(i));
    // clamping of out-of-range delays
    do_reset(5'd0);
    for (int i = 0; i < 4; i++) cyc("clamp1", 1'b1, 1'(i), 8'(8'h50 + i));
    do_reset(5'd20);
    for (int i = 0; i < 20; i++) cyc("clamp16", 1'b1, 1'b1, 8'(8'h60 + i));
    // valid gaps at delay 3
    do_reset(5'd3);
    cyc("gap", 1'b1, 1'b1, 8'hA0);
    cyc("gap", 1'b1, 1'b0, 8'hB0);
    cyc("gap", 1'b1, 1'b1, 8'hC0);
    cyc("gap", 1'b1, 1'b1, 8'hD0);
    for (int i = 0; i < 4; i++) cyc("gap_tail", 1'b1, 1'b0, 8'h00);
    // async reset while primed, checked before the next clock edge
    for (int i = 0; i < 3; i++) cyc("pre_areset", 1'b1, 1'b1, 8'(8'h70 + i));
    check("areset_primed_before", 32'(primed), 32'd1);
    delay_sel = 5'd5;
    reset = 1'b1;
    #1;
    check("areset_dout", 32'(data_out), 32'd0);
    check("areset_vout", 32'(valid_out), 32'd0);
    check("areset_primed", 32'(primed), 32'd0);
    check("areset_adel", 32'(active_delay), 32'd5);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear(5);
    for (int i = 0; i < 8; i++) cyc("after_areset", 1'b1, 1'b1, 8'(8'h80 + i));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_delay_line.md
Name: reg_delay_line

Overview:
- Parametrised successor to the fixed 8-bit register: a WIDTH-bit, MAX_DEPTH-stage shift register with a run-time selectable delay, a stall enable, a valid bit per stage, flush and a primed flag.
- Intended as the per-branch delay element of the convolutional interleaver/deinterleaver. Branch i is instantiated with its own delay_sel.

Parameters:
- WIDTH, 8, data bits per stage.
- MAX_DEPTH, 16, number of physical stages; legal range 1..64.
- DSEL_W, $clog2(MAX_DEPTH+1), width of delay_sel (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  shift enable; 0 = stall, all state held
- flush  in  1  synchronous clear of contents, valid bits and fill count; reloads the delay
- delay_sel  in  DSEL_W  requested delay in stages, 1..MAX_DEPTH
- data_in  in  WIDTH  input word
- valid_in  in  1  input word qualifier
- data_out  out  WIDTH  word delayed by active delay
- valid_out  out  1  qualifier of data_out
- primed  out  1  chain holds active_delay shifts since last clear
- active_delay  out  DSEL_W  delay currently in force

Behaviour:
- Storage: stage[0..MAX_DEPTH-1] of WIDTH bits, vbit[0..MAX_DEPTH-1], fill counter (DSEL_W bits), active_delay register.
- Reset (async, reset=1): all stages and vbits = 0, fill = 0, active_delay = clamp(delay_sel). Outputs: data_out = 0, valid_out = 0, primed = 0.
- clamp(x): 0 -> 1; >MAX_DEPTH -> MAX_DEPTH; otherwise x.
- Shift, on a clk edge with en=1 and flush=0:
  - stage[0] <= data_in, vbit[0] <= valid_in.
  - stage[k] <= stage[k-1], vbit[k] <= vbit[k-1] for k = 1..MAX_DEPTH-1.
  - fill <= min(fill+1, active_delay).
- Stall (en=0, flush=0): every register is held.
- Output tap: data_out = stage[active_delay-1], valid_out = vbit[active_delay-1]. This is a mux from registers only; there is no combinational path from the inputs.
- Latency: a word presented with en=1 at edge N appears on data_out after edge N+active_delay-1 completes. That is, it needs active_delay enabled edges, counting the capture edge. Stalled cycles add no latency count.
- primed = (fill == active_delay).
- Flush: synchronous, priority over en.
  - All stages/vbits <= 0, fill <= 0, active_delay <= clamp(delay_sel).
  - data_in presented in the same cycle is discarded.
- delay_sel is sampled only at reset and at flush. Changes at other times are ignored until the next flush, which avoids corrupt reordering mid-stream.
- MAX_DEPTH=1: behaves as a single enabled register with valid and flush.
- Full/overflow: none. The oldest data falls off stage[MAX_DEPTH-1]. The fill counter saturates and does not wrap.
- Reset mid-stream: asserting reset at any time produces the reset state immediately, without waiting for a clock. Removing it is sampled at the next edge.

Decomposition:
- Package interleaver_pkg: DSEL_W helper function (clog2-based), clamp_delay function, default WIDTH/MAX_DEPTH constants shared with the interleaver top.
- One natural sub-module: reg_stage. It is one WIDTH+1-bit enabled register (data + valid) with async reset and sync clear, generated MAX_DEPTH times. It replaces per-bit flip-flop instantiation. The fill counter, active_delay register and tap mux stay in the parent.

Test Plan:
- Reset/latency: MAX_DEPTH=16, delay_sel=4, reset, then en=1 and feed 0x01,0x02,… with valid=1.
  - data_out=0x01 with valid_out=1 appears after the 4th enabled edge.
  - primed rises on that same edge.
  - valid_out=0 and data_out=0 before it.
- Stall: same stream, drop en for 3 cycles after word 0x03 enters. All outputs are frozen during the stall, and the sequence resumes with no lost or duplicated words.
- Clamp: reset with delay_sel=0 gives active_delay=1 (one-edge delay). Reset with delay_sel=20 on MAX_DEPTH=16 gives active_delay=16.
- Mid-stream delay change: while streaming at delay 4, set delay_sel=7 without flush.
  - Latency stays 4.
  - Then pulse flush with en=1: the next edge gives valid_out=0, primed=0 and active_delay=7.
  - The next word emerges after 7 enabled edges.
- Valid gaps: feed pattern valid=1,0,1,1 with data A,B,C,D at delay 3. valid_out reproduces 1,0,1,1 three edges later, with data A,(B),C,D.
- Async reset mid-stream: assert reset between edges while primed=1. All outputs are 0 before the next clk edge, and active_delay reloads from delay_sel.
